seven_seg_capture: RTL and testbench

Board-level monitor that observes the active-low segment buses of DIGITS seven-segment displays and recovers the hexadecimal value they show. It is the inverse of the hex-to-segment encoders that drive the board HEX displays. A snapshot is published through a valid/ready handshake once the whole bus has been stable long enough. It sits in loopback and self-test paths, where it checks that the display datapath shows what the core wrote.

---
 rtl/seven_seg_capture.sv | 141 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//
// Watches the active-low segment buses of DIGITS seven-segment displays and
// recovers the hexadecimal value they show (the inverse of a hex-to-segment
// encoder). Once the whole bus has held one value for STABLE_CYCLES
// consecutive samples, the decoded snapshot is published through a
// valid/ready handshake. A snapshot that is overwritten before it is
// accepted raises a sticky overflow flag.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   seg_n      segment buses, digit i at [7i+6:7i], bit0=a .. bit6=g, active-low
//   hex_out    decoded nibbles, digit i at [4i+3:4i] (0 for blank/unknown)
//   blank      per digit: pattern was all segments off
//   err        per digit: pattern is neither a hex glyph nor blank
//   out_valid  snapshot available
//   out_ready  consumer accepts the snapshot
//   overflow   sticky: a snapshot was replaced before it was accepted

module seven_seg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7*DIGITS-1:0]   seg_n,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam logic [7:0] RUN_MAX    = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] RUN_TARGET = 8'(STABLE_CYCLES - 2);

    logic [7*DIGITS-1:0] smp;
    logic [7*DIGITS-1:0] last_cap;
    logic                first_done;
    logic [7:0]          run;

    logic                seg_stable;
    logic                capture;
    logic [4*DIGITS-1:0] dec_hex;
    logic [DIGITS-1:0]   dec_blank;
    logic [DIGITS-1:0]   dec_err;

    // Returns {err, blank, nibble} for one active-low segment pattern (g..a).
    function automatic logic [5:0] decode_digit(input logic [6:0] pat);
        logic [5:0] r;
        r = 6'b00_0000;
        case (pat)
            7'h40: r = 6'b00_0000;
            7'h79: r = 6'b00_0001;
            7'h24: r = 6'b00_0010;
            7'h30: r = 6'b00_0011;
            7'h19: r = 6'b00_0100;
            7'h12: r = 6'b00_0101;
            7'h02: r = 6'b00_0110;
            7'h78: r = 6'b00_0111;
            7'h00: r = 6'b00_1000;
            7'h18: r = 6'b00_1001;
            7'h08: r = 6'b00_1010;
            7'h03: r = 6'b00_1011;
            7'h46: r = 6'b00_1100;
            7'h21: r = 6'b00_1101;
            7'h06: r = 6'b00_1110;
            7'h0E: r = 6'b00_1111;
            7'h7F: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    // Decode always looks at the sampled bus; it only reaches the outputs
    // through the capture register, so output pins never glitch.
    always_comb begin
        dec_hex   = '0;
        dec_blank = '0;
        dec_err   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            logic [5:0] d;
            d = decode_digit(smp[7*i +: 7]);
            dec_hex[4*i +: 4] = d[3:0];
            dec_blank[i]      = d[4];
            dec_err[i]        = d[5];
        end
    end

    // run == STABLE_CYCLES-2 together with a matching fresh sample means the
    // bus has now been seen STABLE_CYCLES times in a row. Because run then
    // saturates one above that value, a bus that stays put fires only once.
    assign seg_stable = (seg_n == smp);
    assign capture    = seg_stable && (run == RUN_TARGET) &&
                        ((smp != last_cap) || !first_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp <= '0;
            run <= '0;
        end else begin
            smp <= seg_n;
            if (!seg_stable) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + 8'd1;
            end
        end
    end

    // A capture on the same edge as an accept wins: the consumer took the old
    // snapshot, so the new one is simply pending and overflow stays clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out    <= '0;
            blank      <= '0;
            err        <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            last_cap   <= '0;
            first_done <= 1'b0;
        end else begin
            if (capture) begin
                hex_out    <= dec_hex;
                blank      <= dec_blank;
                err        <= dec_err;
                last_cap   <= smp;
                first_done <= 1'b1;
                out_valid  <= 1'b1;
                if (out_valid && !out_ready) begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
//
// Directed bench for seven_seg_capture (DIGITS=4, STABLE_CYCLES=4). A
// behavioural model tracks how long the bus has kept one value and which
// glyph each digit shows; a compare process checks every output against it
// on every falling edge. Literal expectations at key points pin the model.

module tb_seven_seg_capture;

    localparam int DIGITS        = 4;
    localparam int STABLE_CYCLES = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [27:0]   seg_n     = '0;
    logic          out_ready = 1'b0;
    logic [15:0]   hex_out;
    logic [3:0]    blank;
    logic [3:0]    err;
    logic          out_valid;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    seven_seg_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .hex_out   (hex_out),
        .blank     (blank),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Segment pattern (g..a, active-low) that displays hex digit n.
    function automatic logic [6:0] glyph(input int n);
        case (n)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h18;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] bus4(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Model: look each digit up in the glyph list.
    task automatic modelDecode(input logic [27:0] bus, output logic [15:0] h,
                               output logic [3:0] b, output logic [3:0] e);
        h = '0;
        b = '0;
        e = '0;
        for (int d = 0; d < 4; d++) begin
            logic [6:0] pat;
            bit found;
            pat = bus[7*d +: 7];
            found = 0;
            for (int g = 0; g < 16; g++) begin
                if (!found && glyph(g) == pat) begin
                    h[4*d +: 4] = 4'(g);
                    found = 1;
                end
            end
            if (!found) begin
                if (pat == 7'h7F) b[d] = 1'b1;
                else              e[d] = 1'b1;
            end
        end
    endtask

    // Model state: streak counts identical consecutive samples, with the
    // cleared sample register after reset counting as one sample of zero.
    logic [27:0] m_prev   = '0;
    int          m_streak = 1;
    bit          m_have   = 0;
    logic [27:0] m_last   = '0;
    logic [15:0] m_hex    = '0;
    logic [3:0]  m_blank  = '0;
    logic [3:0]  m_err    = '0;
    logic        m_valid  = 1'b0;
    logic        m_ovf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev   = '0;
            m_streak = 1;
            m_have   = 0;
            m_last   = '0;
            m_hex    = '0;
            m_blank  = '0;
            m_err    = '0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            if (seg_n == m_prev) m_streak++;
            else                 m_streak = 1;
            m_prev = seg_n;
            if (m_streak == STABLE_CYCLES && (!m_have || seg_n != m_last)) begin
                if (m_valid && !out_ready) m_ovf = 1'b1;
                modelDecode(seg_n, m_hex, m_blank, m_err);
                m_valid = 1'b1;
                m_last  = seg_n;
                m_have  = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("model overflow",  32'(overflow),  32'(m_ovf));
        checkOutput("model hex_out",   32'(hex_out),   32'(m_hex));
        checkOutput("model blank",     32'(blank),     32'(m_blank));
        checkOutput("model err",       32'(err),       32'(m_err));
    end

    // Advance n falling edges, then 1 time unit so stimulus and literal
    // checks never coincide with either clock edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [27:0] bus, input logic ready);
        seg_n     = bus;
        out_ready = ready;
    endtask

    initial begin
        step(2);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset overflow",  32'(overflow),  32'h0);
        checkOutput("reset hex_out",   32'(hex_out),   32'h0);
        checkOutput("reset blank",     32'(blank),     32'h0);
        checkOutput("reset err",       32'(err),       32'h0);

        // First capture: 0123 appears after the fourth edge.
        applyStimulus(bus4(7'h40, 7'h79, 7'h24, 7'h30), 1'b0);
        rst = 1'b0;
        step(3);
        checkOutput("first not early", 32'(out_valid), 32'h0);
        step(1);
        checkOutput("first valid", 32'(out_valid), 32'h1);
        checkOutput("first hex",   32'(hex_out),   32'h0123);
        checkOutput("first blank", 32'(blank),     32'h0);
        checkOutput("first err",   32'(err),       32'h0);

        // Unchanged bus never recaptures; single-cycle ready accepts.
        step(20);
        checkOutput("hold valid",    32'(out_valid), 32'h1);
        checkOutput("hold overflow", 32'(overflow),  32'h0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checkOutput("accept clears", 32'(out_valid), 32'h0);
        step(5);
        checkOutput("no recapture", 32'(out_valid), 32'h0);

        // Toggling faster than the window never captures.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(bus4(7'h40, 7'h79, 7'h24, (i % 2 == 0) ? 7'h12 : 7'h30), 1'b0);
            step(2);
        end
        checkOutput("toggle no capture", 32'(out_valid), 32'h0);
        applyStimulus(bus4(7'h40, 7'h79, 7'h24, 7'h12), 1'b0);
        step(3);
        checkOutput("settle not early", 32'(out_valid), 32'h0);
        step(1);
        checkOutput("settle valid", 32'(out_valid), 32'h1);
        checkOutput("settle hex",   32'(hex_out),   32'h0125);

        // Blank and unknown digits.
        out_ready = 1'b1;
        step(1);
        applyStimulus(bus4(7'h40, 7'h7F, 7'h55, 7'h30), 1'b0);
        step(3);
        checkOutput("blank not early", 32'(out_valid), 32'h0);
        step(1);
        checkOutput("blank valid",    32'(out_valid), 32'h1);
        checkOutput("blank hex",      32'(hex_out),   32'h0003);
        checkOutput("blank flags",    32'(blank),     32'h4);
        checkOutput("err flags",      32'(err),       32'h2);
        checkOutput("blank overflow", 32'(overflow),  32'h0);

        // Second capture while unaccepted replaces the first and overflows.
        applyStimulus(bus4(7'h79, 7'h79, 7'h79, 7'h79), 1'b0);
        step(4);
        checkOutput("ovf valid", 32'(out_valid), 32'h1);
        checkOutput("ovf hex",   32'(hex_out),   32'h1111);
        checkOutput("ovf flag",  32'(overflow),  32'h1);
        checkOutput("ovf err",   32'(err),       32'h0);

        // Reset mid-window discards everything, even the sticky flag.
        applyStimulus(bus4(7'h24, 7'h24, 7'h24, 7'h24), 1'b0);
        step(2);
        rst = 1'b1;
        applyStimulus(bus4(7'h79, 7'h79, 7'h79, 7'h79), 1'b0);
        step(2);
        checkOutput("rst2 valid",    32'(out_valid), 32'h0);
        checkOutput("rst2 overflow", 32'(overflow),  32'h0);
        checkOutput("rst2 hex",      32'(hex_out),   32'h0);
        rst = 1'b0;
        step(3);
        checkOutput("post rst not early", 32'(out_valid), 32'h0);
        step(1);
        checkOutput("post rst valid",    32'(out_valid), 32'h1);
        checkOutput("post rst hex",      32'(hex_out),   32'h1111);
        checkOutput("post rst overflow", 32'(overflow),  32'h0);

        // Every glyph through digit 0 with the consumer always ready.
        for (int g = 0; g < 16; g++) begin
            applyStimulus(bus4(7'h40, 7'h40, 7'h40, glyph(g)), 1'b1);
            step(4);
            checkOutput("glyph valid", 32'(out_valid), 32'h1);
            checkOutput("glyph hex",   32'(hex_out),   32'(g));
            checkOutput("glyph err",   32'(err),       32'h0);
        end
        out_ready = 1'b0;
        step(2);
        checkOutput("final overflow", 32'(overflow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
